// File: rtl/ntt_bf_sched.sv
// ntt_bf_sched: stage/cycle scheduler for the radix-2, 8-BFU NTT datapath.
// Generates per-bank row addresses and butterfly input-crossbar select codes
// for each issue cycle, and a copy delayed by BF_LAT+1 cycles for write-back.
//
// Optional feature macro: BF_SCHED_INTT_EN (adds the inv port; inv=1 at start
// runs the stages in descending order).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle run request, ignored unless idle
//   inv             stage order select, sampled with start (BF_SCHED_INTT_EN only)
//   busy            high from first issue cycle through last drain cycle
//   done            one-cycle completion pulse
//   stage           current stage index
//   rd_en/rd_addr/sel  bank read strobe, per-bank row, per-bank crossbar code
//   wr_en/wr_addr/wr_sel  the read triple delayed by BF_LAT+1 cycles
module ntt_bf_sched #(
  parameter int unsigned LOG_N  = 8,
  parameter int unsigned BF_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
`ifdef BF_SCHED_INTT_EN
  input  logic                    inv,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              stage,
  output logic                    rd_en,
  output logic [16*(LOG_N-4)-1:0] rd_addr,
  output logic [63:0]             sel,
  output logic                    wr_en,
  output logic [16*(LOG_N-4)-1:0] wr_addr,
  output logic [63:0]             wr_sel
);

  localparam int unsigned ROW_W = LOG_N - 4;
  localparam int unsigned DCW   = (BF_LAT < 1) ? 1 : $clog2(BF_LAT + 1);
  localparam int unsigned DEPTH = BF_LAT + 1;
  localparam int unsigned PW    = 1 + 16 * ROW_W + 64;
  localparam logic [3:0]  STAGE_LAST = 4'(LOG_N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   t_q, t_d;
  logic [DCW-1:0]     dcnt_q, dcnt_d;
  logic [3:0]         stage_q, stage_d;
  logic               desc_q, desc_d;
  logic               start_desc;
  logic               last_stage;
  logic [PW-1:0]      pipe_q [DEPTH];
  logic [PW-1:0]      pipe_d [DEPTH];

`ifdef BF_SCHED_INTT_EN
  assign start_desc = inv;
`else
  assign start_desc = 1'b0;
`endif

  assign last_stage = desc_q ? (stage_q == 4'd0) : (stage_q == STAGE_LAST);

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      dcnt_q  <= '0;
      stage_q <= '0;
      desc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      dcnt_q  <= dcnt_d;
      stage_q <= stage_d;
      desc_q  <= desc_d;
    end
  end

  // Next-state: ISSUE for R cycles, DRAIN for BF_LAT+1, then next stage or FIN
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    dcnt_d  = dcnt_q;
    stage_d = stage_q;
    desc_d  = desc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          t_d     = '0;
          dcnt_d  = '0;
          desc_d  = start_desc;
          stage_d = start_desc ? STAGE_LAST : 4'd0;
        end
      end
      S_ISSUE: begin
        if (&t_q) begin
          state_d = S_DRAIN;
          t_d     = '0;
          dcnt_d  = '0;
        end else begin
          t_d = t_q + ROW_W'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DCW'(BF_LAT)) begin
          dcnt_d = '0;
          if (last_stage) begin
            state_d = S_FIN;
          end else begin
            state_d = S_ISSUE;
            stage_d = desc_q ? (stage_q - 4'd1) : (stage_q + 4'd1);
          end
        end else begin
          dcnt_d = dcnt_q + DCW'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done  = (state_q == S_FIN);
  assign rd_en = (state_q == S_ISSUE);
  assign stage = stage_q;

  // Read address / crossbar code generation
  logic [3:0]       sbit, low4, c, bb;
  logic [2:0]       k;
  logic [3:0]       m;
  logic [ROW_W-1:0] mbit, mlow, p, r, rp;

  always_comb begin
    rd_addr = '0;
    sel     = '0;
    sbit    = '0;
    low4    = '0;
    c       = '0;
    bb      = '0;
    k       = '0;
    m       = '0;
    mbit    = '0;
    mlow    = '0;
    p       = '0;
    r       = '0;
    rp      = '0;
    if (state_q == S_ISSUE) begin
      if (stage_q < 4'd4) begin
        // In-row stages: every bank reads row t; the column bit at position s
        // picks hi/lo, the remaining three column bits name the butterfly.
        sbit = 4'd1 << stage_q[1:0];
        low4 = sbit - 4'd1;
        for (int b = 0; b < 16; b++) begin
          c = 4'(b) ^ {^t_q, 3'b000};
          k = 3'(((c >> 1) & ~low4) | (c & low4));
          rd_addr[b*ROW_W +: ROW_W] = t_q;
          sel[4*b +: 4] = {k, |(c & sbit)};
        end
      end else begin
        // Cross-row stages: row pair (r, r') differs in bit m; the parity
        // swizzle of the storage map places each half in distinct banks.
        m    = stage_q - 4'd4;
        mbit = ROW_W'(1) << m;
        mlow = mbit - ROW_W'(1);
        p    = t_q >> 1;
        r    = ((p & ~mlow) << 1) | (p & mlow);
        rp   = r | mbit;
        for (int b = 0; b < 16; b++) begin
          bb = 4'(b);
          if ((bb[3] ^ (^r)) == t_q[0]) begin
            rd_addr[b*ROW_W +: ROW_W] = r;
            sel[4*b +: 4] = {bb[2:0], 1'b0};
          end else begin
            rd_addr[b*ROW_W +: ROW_W] = rp;
            sel[4*b +: 4] = {bb[2:0], 1'b1};
          end
        end
      end
    end
  end

  // Write-back delay line
  always_comb begin
    pipe_d[0] = {rd_en, rd_addr, sel};
    for (int i = 1; i < int'(DEPTH); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign {wr_en, wr_addr, wr_sel} = pipe_q[DEPTH-1];

endmodule

// File: doc/ntt_bf_sched.md
# ntt_bf_sched

Stage/cycle scheduler for the radix-2, 8-BFU NTT datapath. It drives the 16 coefficient banks and the 4-bit per-bank select codes that the butterfly input crossbar consumes. It also emits delayed write-back addresses and selects for the output crossbar. It sits between the top-level control (start/done) and the bank memories plus crossbar networks.

## Interface
- LOG_N, default 8: log2 of transform size N; legal range 5..12.
- BF_LAT, default 3: butterfly pipeline latency in cycles, ≥1.
- ROW_W (local), LOG_N-4: bank address width. R = 2^ROW_W rows per bank.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; ignored while busy.
- inv  in  1  direction select; sampled with start; only present when BF_SCHED_INTT_EN is defined.
- busy  out  1  high from first issue cycle through last drain cycle.
- done  out  1  one-cycle pulse after completion.
- stage  out  4  current stage index.
- rd_en  out  1  bank read strobe.
- rd_addr  out  16*ROW_W  per-bank row address; bank b occupies bits [b*ROW_W +: ROW_W].
- sel  out  64  per-bank crossbar code; bank b occupies [4b +: 4]. Code 2k routes to u_k, 2k+1 routes to v_k.
- wr_en, wr_addr, wr_sel  out  1, 16*ROW_W, 64  rd_en/rd_addr/sel delayed by BF_LAT+1 cycles.

## Operation
- Storage map: coefficient i is at row r = i>>4, bank = i[3:0] ^ {par(r),3'b000}, where par is the XOR-reduce of r.
- FSM states: IDLE → ISSUE → DRAIN → (ISSUE for next stage | FIN) → IDLE.
  - ISSUE lasts R cycles, with cycle counter t = 0..R-1.
  - DRAIN lasts BF_LAT+1 cycles.
  - FIN lasts 1 cycle; done is asserted in FIN.
- Stage order: s = 0..LOG_N-1 ascending.
- Stage s<4, with d = 2^s:
  - All banks read row t.
  - Bank b holds column c = b ^ 8·par(t).
  - Butterfly k uses lo = ((k>>s)<<(s+1)) | (k & (d-1)) and hi = lo+d.
  - sel for bank b is 2k if c==lo(k), and 2k+1 if c==hi(k).
- Stage s≥4, with m = s-4:
  - h = t[0] and p = t>>1.
  - r = p with a 0 inserted at bit m; r' = r | (1<<m).
  - Bank b reads row r if (b[3]^par(r))==h, otherwise row r'.
  - sel = 2·b[2:0] for the r read and 2·b[2:0]+1 for the r' read.
- The mapping is conflict-free: exactly one read per bank per issue cycle.
- rd_en=1 only in ISSUE. rd_addr and sel are driven combinationally from the state registers and are 0 outside ISSUE.
- The write-back path is a BF_LAT+1-deep shift register of {rd_en, rd_addr, sel}.
- start while busy or in FIN: ignored.

## Timing
- All outputs reset to 0. FSM resets to IDLE, counters reset to 0, and the write-back pipeline is cleared.
- A start accepted in cycle 0 gives the first rd_en in cycle 1.
- Stage s occupies cycles 1+s·(R+BF_LAT+1) .. (s+1)·(R+BF_LAT+1).
- busy is high in cycles 1..LOG_N·(R+BF_LAT+1). done pulses the following cycle, with busy low.
- sel is presented in the same cycle as rd_addr. The crossbar registers sel, aligning it with 1-cycle bank read data.
- The last write of a stage lands in that stage's last DRAIN cycle. The next stage's first read occurs one cycle later, which guarantees read-after-write.
- Wrap-around: t wraps to 0 at R-1, and stage increments on DRAIN exit.
- rst mid-operation: immediate return to IDLE. No done pulse and no further wr_en.

## Configuration
- BF_SCHED_INTT_EN defined:
  - Port inv exists.
  - inv=1 at start runs stages LOG_N-1 down to 0, using identical per-stage mapping and timing.
  - inv=0 runs ascending order.
- BF_SCHED_INTT_EN undefined: inv is absent and order is always ascending.

## Test plan
All scenarios use LOG_N=5 and BF_LAT=3.
- Reset then idle: all outputs 0; a start pulse while rst=1 is ignored.
- Stage 0:
  - t=0: all rd_addr=0, bank b sel=b.
  - t=1: all rd_addr=1, bank b sel=b^8.
- Stage 4:
  - t=0: banks 0–7 addr 0 with sel 2b; banks 8–15 addr 1 with sel 2(b-8)+1.
  - t=1: banks 8–15 addr 0 with sel 2(b-8); banks 0–7 addr 1 with sel 2b+1.
- Full run from start in cycle 0:
  - busy is high in cycles 1–30 and done pulses in cycle 31.
  - Exactly 10 rd_en and 10 wr_en cycles occur.
  - Each wr_en follows its rd_en by exactly 4 cycles.
- A start asserted in cycle 10 is ignored; a reset asserted in cycle 12 gives all outputs 0 in cycle 12 and no done pulse.
- With BF_SCHED_INTT_EN defined, start with inv=1: the stage output sequence is 4,3,2,1,0, and stage-4 addresses match the third scenario.
